// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: latches operands onto the ALU, waits LAT cycles, captures the result.
// Optional back-to-back issue from DONE is enabled by defining ALU_B2B_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no op in flight, ready to accept a request
// S_WAIT | operands driven to ALU, counting down settle cycles
// S_DONE | result captured and presented downstream until accepted
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              busy
);

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("alu_issue_ctrl: LAT=%0d outside legal range 1..15", LAT);
  end

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [3:0]          cnt_q,      cnt_d;
  logic [DATA_W-1:0]   alu_a_q,    alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,    alu_b_d;
  logic [OP_W-1:0]     alu_op_q,   alu_op_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                accept;

  // Reset gates ready so no handshake can complete during a reset cycle.
  always_comb begin
    req_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE:  req_ready = 1'b1;
`ifdef ALU_B2B_EN
        S_DONE:  req_ready = rsp_ready;
`endif
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;

    if (accept) begin
      alu_a_d  = req_a;
      alu_b_d  = req_b;
      alu_op_d = req_op;
      cnt_d    = LAT_CNT;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_data_d = alu_result;
          rsp_zero_d = alu_zero;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = accept ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three instances (LAT 1, 3, 4) share stimulus; directed steps then
// randomized traffic checked against a cycle-stamp transaction model. Honours ALU_B2B_EN.
module tb_alu_issue_ctrl;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int N  = 3;
`ifdef ALU_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [DW-1:0] req_a, req_b;
  logic [OW-1:0] req_op;
  logic          rsp_ready;

  logic          req_ready [N];
  logic [DW-1:0] alu_a [N];
  logic [DW-1:0] alu_b [N];
  logic [OW-1:0] alu_op [N];
  logic [DW-1:0] alu_result [N];
  logic          alu_zero [N];
  logic          rsp_valid [N];
  logic [DW-1:0] rsp_data [N];
  logic          rsp_zero [N];
  logic          busy [N];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int lat_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // Behavioural ALU sitting on the DUT's operand outputs.
  function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    alu_issue_ctrl #(.DATA_W(DW), .OP_W(OW), .LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
      .alu_result(alu_result[g]), .alu_zero(alu_zero[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data[g]), .rsp_zero(rsp_zero[g]),
      .busy(busy[g])
    );
    assign alu_result[g] = alu_fn(alu_a[g], alu_b[g], alu_op[g]);
    assign alu_zero[g]   = (alu_result[g] == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Transaction model: one op in flight per instance, response visible LAT edges after accept.
  bit            pend [N];
  int            rdy_at [N];
  logic [DW-1:0] m_a [N], m_b [N], m_res [N];
  logic [OW-1:0] m_op [N];
  bit            rhs [N], qhs [N];
  int            cyc;
  int            pulse_c [$];
  logic [DW-1:0] pulse_d [$];
  bit            hs;
  int            idx;
  logic [DW-1:0] ev_a, ev_b;

  initial begin
    // 1: reset with a request pending
    reset = 1'b1; req_valid = 1'b1; req_a = 32'd11; req_b = 32'd22; req_op = 4'd0; rsp_ready = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t1.req_ready_in_reset[%0d]", k), req_ready[k], 0);
      chk($sformatf("t1.busy[%0d]", k), busy[k], 0);
      chk($sformatf("t1.rsp_valid[%0d]", k), rsp_valid[k], 0);
      chk($sformatf("t1.alu_a[%0d]", k), alu_a[k], 0);
      chk($sformatf("t1.rsp_data[%0d]", k), rsp_data[k], 0);
    end
    tick();
    reset = 1'b0; req_valid = 1'b0;
    #1;
    for (int k = 0; k < N; k++)
      chk($sformatf("t1.req_ready_release[%0d]", k), req_ready[k], 1);

    // 2: LAT=1, 5+3
    req_valid = 1'b1; req_a = 32'd5; req_b = 32'd3; req_op = 4'd0; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t2.alu_a", alu_a[0], 5);
    chk("t2.alu_b", alu_b[0], 3);
    chk("t2.rsp_valid_e0", rsp_valid[0], 0);
    chk("t2.busy_e0", busy[0], 1);
    tick();
    chk("t2.rsp_valid_e1", rsp_valid[0], 1);
    chk("t2.rsp_data", rsp_data[0], 8);
    chk("t2.rsp_zero", rsp_zero[0], 0);
    tick();
    chk("t2.rsp_valid_after", rsp_valid[0], 0);
    chk("t2.busy_after", busy[0], 0);
    do_reset();

    // 3 + 6: LAT=3, 7-7 with back-pressure, operands changed while waiting
    req_valid = 1'b1; req_a = 32'd7; req_b = 32'd7; req_op = 4'd1; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_a = 32'd9; req_b = 32'd1;
    for (int c = 1; c < 3; c++) begin
      tick();
      chk($sformatf("t3.rsp_valid_e%0d", c), rsp_valid[1], 0);
      chk($sformatf("t6.alu_a_e%0d", c), alu_a[1], 7);
      chk($sformatf("t6.alu_b_e%0d", c), alu_b[1], 7);
    end
    tick();
    chk("t3.rsp_valid_e3", rsp_valid[1], 1);
    chk("t3.rsp_data_e3", rsp_data[1], 0);
    chk("t3.rsp_zero_e3", rsp_zero[1], 1);
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t3.hold_valid%0d", c), rsp_valid[1], 1);
      chk($sformatf("t3.hold_data%0d", c), rsp_data[1], 0);
      chk($sformatf("t3.hold_zero%0d", c), rsp_zero[1], 1);
      chk($sformatf("t3.hold_busy%0d", c), busy[1], 1);
      chk($sformatf("t3.hold_ready%0d", c), req_ready[1], 0);
      chk($sformatf("t6.hold_alu_a%0d", c), alu_a[1], 7);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("t3.idle_valid", rsp_valid[1], 0);
    chk("t3.idle_busy", busy[1], 0);
    do_reset();

    // 4: back-to-back on LAT=1
    rsp_ready = 1'b1; req_valid = 1'b1; req_a = 32'd1; req_b = 32'd2; req_op = 4'd0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      hs = req_valid && req_ready[0];
      tick();
      if (hs) begin
        idx++;
        if (idx == 1) begin req_a = 32'd4; req_b = 32'd4; end
        else req_valid = 1'b0;
      end
      if (rsp_valid[0]) begin pulse_c.push_back(c); pulse_d.push_back(rsp_data[0]); end
    end
    chk("t4.pulse_count", pulse_c.size(), 2);
    if (pulse_c.size() == 2) begin
      chk("t4.data0", pulse_d[0], 3);
      chk("t4.data1", pulse_d[1], 8);
      chk("t4.spacing", pulse_c[1] - pulse_c[0], B2B ? 2 : 3);
    end
    do_reset();

    // 5: reset in WAIT with LAT=4, cnt=2
    rsp_ready = 1'b1; req_valid = 1'b1; req_a = 32'd10; req_b = 32'd20; req_op = 4'd0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("t5.busy_before", busy[2], 1);
    chk("t5.valid_before", rsp_valid[2], 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5.busy_after", busy[2], 0);
    chk("t5.valid_after", rsp_valid[2], 0);
    chk("t5.alu_a_after", alu_a[2], 0);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rsp_valid[2]) idx++;
    end
    chk("t5.no_stale_rsp", idx, 0);

    // Randomized traffic
    do_reset();
    cyc = 0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int it = 0; it < 600; it++) begin
      reset     = ($urandom_range(0, 59) == 0);
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 6);
      req_a     = $urandom();
      req_b     = ($urandom_range(0, 3) == 0) ? req_a : $urandom();
      req_op    = 4'($urandom_range(0, 7));
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        bit ev, er;
        ev = pend[k] && (cyc >= rdy_at[k]);
        er = !reset && (!pend[k] || (B2B && ev && rsp_ready));
        chk($sformatf("rnd%0d.k%0d.rsp_valid", it, k), rsp_valid[k], ev);
        chk($sformatf("rnd%0d.k%0d.req_ready", it, k), req_ready[k], er);
        chk($sformatf("rnd%0d.k%0d.busy", it, k), busy[k], pend[k]);
        if (ev) begin
          chk($sformatf("rnd%0d.k%0d.rsp_data", it, k), rsp_data[k], m_res[k]);
          chk($sformatf("rnd%0d.k%0d.rsp_zero", it, k), rsp_zero[k], (m_res[k] == '0));
        end
        if (pend[k]) begin
          ev_a = alu_a[k]; ev_b = alu_b[k];
          chk($sformatf("rnd%0d.k%0d.alu_ops", it, k), {ev_a, ev_b}, {m_a[k], m_b[k]});
          chk($sformatf("rnd%0d.k%0d.alu_op", it, k), alu_op[k], m_op[k]);
        end
        rhs[k] = ev && rsp_ready;
        qhs[k] = req_valid && er;
      end
      @(posedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (reset) pend[k] = 1'b0;
        else begin
          if (rhs[k]) pend[k] = 1'b0;
          if (qhs[k]) begin
            pend[k]   = 1'b1;
            rdy_at[k] = cyc + lat_of(k);
            m_a[k]    = req_a;
            m_b[k]    = req_b;
            m_op[k]   = req_op;
            m_res[k]  = alu_fn(req_a, req_b, req_op);
          end
        end
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
